// File: rtl/conbus_test_slave_pkg.sv
// Shared definitions for the conbus Wishbone test slave: FSM states, the only
// legal cycle type, and the Galois LFSR step used for wait-state generation.
package conbus_test_slave_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_e;

  localparam logic [2:0]  CTI_CLASSIC = 3'b000;

  // Right-shifting Galois form of x^32 + x^22 + x^2 + x + 1
  localparam logic [31:0] LFSR_TAPS   = 32'h8020_0003;

  function automatic logic [31:0] lfsr_next(input logic [31:0] q);
    return {1'b0, q[31:1]} ^ (q[0] ? LFSR_TAPS : '0);
  endfunction

endpackage

// File: rtl/conbus_test_slave_lfsr.sv
// 32-bit Galois LFSR (taps 32,22,2,1); loads seed on reset, steps when en=1.
module conbus_test_lfsr
  import conbus_test_slave_pkg::*;
(
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        en,
  input  logic [31:0] seed,
  output logic [31:0] q
);

  logic [31:0] q_q;
  logic [31:0] q_d;

  always_comb begin
    q_d = q_q;
    if (en) q_d = lfsr_next(q_q);
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) q_q <= seed;
    else         q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/conbus_test_slave.sv
// Wishbone classic test slave: byte-lane word memory, pseudo-random wait
// states from an LFSR, transaction counters and a sticky protocol-error flag.
module conbus_test_slave
  import conbus_test_slave_pkg::*;
#(
  parameter int unsigned id    = 0,
  parameter int unsigned aw    = 6,
  parameter int unsigned wbits = 2,
  parameter logic [31:0] seed  = 32'hACE1,
  parameter int unsigned cw    = 16
) (
  input  logic          sys_clk,
  input  logic          sys_rst,
  input  logic [31:0]   adr,
  input  logic [31:0]   dat_w,
  output logic [31:0]   dat_r,
  input  logic [3:0]    sel,
  input  logic          we,
  input  logic [2:0]    cti,
  input  logic          cyc,
  input  logic          stb,
  output logic          ack,
  output logic [cw-1:0] rcount,
  output logic [cw-1:0] wcount,
  output logic          err
);

  localparam int unsigned DEPTH = 1 << aw;

  state_e             state_q, state_d;
  logic [wbits-1:0]   wcnt_q, wcnt_d;
  logic [31:0]        adr_q, dat_q;
  logic [3:0]         sel_q;
  logic               we_q;
  logic               err_q, err_d;
  logic [cw-1:0]      rcount_q, rcount_d;
  logic [cw-1:0]      wcount_q, wcount_d;
  logic [31:0]        mem_q [DEPTH] = '{default: '0};

  logic               req;
  logic               latch;
  logic               lfsr_en;
  logic [31:0]        lfsr_q;
  logic               commit;
  logic               cmt_we;
  logic [3:0]         cmt_sel;
  logic [31:0]        cmt_dat;
  logic [aw-1:0]      cmt_idx;
  logic               mismatch;
  logic               unused_ok;

  conbus_test_lfsr u_lfsr (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .en      (lfsr_en),
    .seed    (seed),
    .q       (lfsr_q)
  );

  assign req      = cyc & stb;
  assign mismatch = (adr != adr_q) | (we != we_q) | (sel != sel_q) | (dat_w != dat_q);

  // A zero-wait request commits on its accept edge, before the latches hold it
  always_comb begin
    if (state_q == ST_IDLE) begin
      cmt_we  = we;
      cmt_sel = sel;
      cmt_dat = dat_w;
      cmt_idx = adr[aw+1:2];
    end else begin
      cmt_we  = we_q;
      cmt_sel = sel_q;
      cmt_dat = dat_q;
      cmt_idx = adr_q[aw+1:2];
    end
  end

  always_comb begin
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    err_d    = err_q;
    rcount_d = rcount_q;
    wcount_d = wcount_q;
    latch    = 1'b0;
    lfsr_en  = 1'b0;
    commit   = 1'b0;

    if (stb && !cyc) err_d = 1'b1;

    unique case (state_q)
      ST_IDLE: begin
        if (req) begin
          latch   = 1'b1;
          lfsr_en = 1'b1;
          wcnt_d  = lfsr_q[wbits-1:0];
          if (cti != CTI_CLASSIC) err_d = 1'b1;
          if (lfsr_q[wbits-1:0] == '0) begin
            state_d = ST_ACK;
            commit  = 1'b1;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (!req) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          if (mismatch) err_d = 1'b1;
          wcnt_d = wcnt_q - wbits'(1);
          if (wcnt_q == wbits'(1)) begin
            state_d = ST_ACK;
            commit  = 1'b1;
          end
        end
      end
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (commit) begin
      if (cmt_we) wcount_d = wcount_q + cw'(1);
      else        rcount_d = rcount_q + cw'(1);
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q  <= ST_IDLE;
      wcnt_q   <= '0;
      err_q    <= 1'b0;
      rcount_q <= '0;
      wcount_q <= '0;
    end else begin
      state_q  <= state_d;
      wcnt_q   <= wcnt_d;
      err_q    <= err_d;
      rcount_q <= rcount_d;
      wcount_q <= wcount_d;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (latch) begin
      adr_q <= adr;
      dat_q <= dat_w;
      sel_q <= sel;
      we_q  <= we;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (commit && cmt_we && !sys_rst) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (cmt_sel[i]) mem_q[cmt_idx][8*i +: 8] <= cmt_dat[8*i +: 8];
      end
    end
  end

  assign ack    = (state_q == ST_ACK);
  assign dat_r  = ack ? mem_q[adr_q[aw+1:2]] : '0;
  assign rcount = rcount_q;
  assign wcount = wcount_q;
  assign err    = err_q;

  assign unused_ok = ^{lfsr_q, 32'(id)};

endmodule
